// File: rtl/mssd_tx.sv
// mssd_tx: serial frame transmitter.
// Frame on serOut: start bit (0), 8-bit header {len, port} MSB first,
// len*8 payload bits (each byte MSB first), stop bit, then IDLE_GAP high cycles.
// Payload bytes enter through a one-entry buffer using a valid/ready handshake.
// If the buffer is empty at a byte boundary (underrun), the rest of the
// payload is sent as zeros, the stop bit is 0 and error pulses.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   start      - frame request, sampled when idle
//   port, len  - destination port and payload length (0 = 64 bytes), latched on accept
//   byte_in, byte_valid / byte_ready - payload byte handshake
//   serOut     - registered serial line, idle high
//   busy       - frame in progress, including the idle gap
//   done       - one-cycle pulse on a good stop bit
//   error      - one-cycle pulse on a frame aborted by underrun
module mssd_tx #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] port,
  input  logic [5:0] len,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       serOut,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned LEN_W = 7;

  typedef enum logic [2:0] {IDLE, START, HEADER, DATA, STOP, GAP} state_t;

  state_t             state;
  logic [7:0]         hdr;
  logic [2:0]         hcnt;
  logic [CNT_W-1:0]   bits_left;   // payload bits remaining after the current one
  logic [6:0]         sh;          // unsent bits of the current byte
  logic [7:0]         byte_buf;
  logic               buf_full;
  logic [LEN_W-1:0]   acc;         // bytes accepted this frame
  logic [LEN_W-1:0]   len_eff;
  logic               underrun;
  logic [GAP_W-1:0]   gcnt;

  logic               load_now;
  logic               have_byte;
  logic               ld_bit;
  logic [6:0]         ld_sh;
  logic               xfer;
  logic               accept;

  // Handshake and byte-boundary decode
  always_comb begin
    load_now   = ((state == HEADER) && (hcnt == 3'd7)) ||
                 ((state == DATA) && (bits_left[2:0] == 3'd0) && (bits_left != '0));
    byte_ready = ((state == START) || (state == HEADER) || (state == DATA)) &&
                 !underrun && (acc < len_eff) && (!buf_full || load_now);
    xfer       = byte_valid && byte_ready;
    have_byte  = buf_full && !underrun;
    ld_bit     = have_byte ? byte_buf[7]   : 1'b0;
    ld_sh      = have_byte ? byte_buf[6:0] : 7'd0;
    // The last gap cycle also samples start so back-to-back frames keep
    // exactly IDLE_GAP high cycles between stop and start bits.
    accept     = start && ((state == IDLE) || ((state == GAP) && (gcnt == '0)));
  end

  // Frame sequencer with registered line and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      serOut    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      hdr       <= '0;
      hcnt      <= '0;
      bits_left <= '0;
      sh        <= '0;
      byte_buf  <= '0;
      buf_full  <= 1'b0;
      acc       <= '0;
      len_eff   <= '0;
      underrun  <= 1'b0;
      gcnt      <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;

      // Shifter load empties the buffer; a same-cycle transfer refills it
      if (load_now) buf_full <= 1'b0;
      if (xfer) begin
        byte_buf <= byte_in;
        buf_full <= 1'b1;
        acc      <= acc + LEN_W'(1);
      end

      unique case (state)
        IDLE: begin
          serOut <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          state  <= HEADER;
          serOut <= hdr[7];
          hdr    <= {hdr[6:0], 1'b0};
          hcnt   <= '0;
        end
        HEADER: begin
          if (hcnt == 3'd7) begin
            state     <= DATA;
            bits_left <= CNT_W'({len_eff, 3'b000} - 10'd1);
            serOut    <= ld_bit;
            sh        <= ld_sh;
            if (!have_byte) underrun <= 1'b1;
          end else begin
            serOut <= hdr[7];
            hdr    <= {hdr[6:0], 1'b0};
            hcnt   <= hcnt + 3'd1;
          end
        end
        DATA: begin
          if (bits_left == '0) begin
            state  <= STOP;
            serOut <= !underrun;
            done   <= !underrun;
            error  <= underrun;
          end else begin
            bits_left <= bits_left - CNT_W'(1);
            if (load_now) begin
              serOut <= ld_bit;
              sh     <= ld_sh;
              if (!have_byte) underrun <= 1'b1;
            end else begin
              serOut <= sh[6];
              sh     <= {sh[5:0], 1'b0};
            end
          end
        end
        STOP: begin
          state  <= GAP;
          serOut <= 1'b1;
          gcnt   <= GAP_W'(IDLE_GAP - 1);
        end
        GAP: begin
          serOut <= 1'b1;
          if (gcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          serOut <= 1'b1;
          busy   <= 1'b0;
        end
      endcase

      if (accept) begin
        state    <= START;
        serOut   <= 1'b0;
        busy     <= 1'b1;
        hdr      <= {len, port};
        len_eff  <= (len == 6'd0) ? LEN_W'(64) : LEN_W'(len);
        acc      <= '0;
        underrun <= 1'b0;
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mssd_tx.sv
// Self-checking bench for mssd_tx: frames are captured cycle by cycle and
// compared against an expected waveform built from the frame format.
module tb_mssd_tx;

  localparam int unsigned GAP_CYC = 3;
  localparam int MAXC = 600;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] port;
  logic [5:0] len;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       serOut;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] data_q [64];
  logic [3:0] obs_v  [MAXC];   // {serOut, busy, done, error} per frame cycle
  logic [3:0] exp_v  [MAXC];
  int         n_xfer;

  mssd_tx #(.IDLE_GAP(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .port(port), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .serOut(serOut), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [5:0] l);
    return (l == 6'd0) ? 64 : int'(l);
  endfunction

  function automatic int frame_cycles(input logic [5:0] l);
    return 10 + eff_len(l) * 8 + int'(GAP_CYC) + 1;
  endfunction

  // Issue a start and record ncyc cycles; the source offers the first k bytes
  // as soon as it can and then goes silent.
  task automatic run_frame(input logic [1:0] p, input logic [5:0] l, input int k,
                           input bit hold, input int ncyc);
    int  sent;
    logic x;
    sent       = 0;
    port       = p;
    len        = l;
    start      = 1'b1;
    byte_valid = (k > 0);
    byte_in    = data_q[0];
    for (int c = 1; c <= ncyc; c++) begin
      x = byte_valid && byte_ready;
      tick();
      if (x) sent++;
      if (!hold) start = 1'b0;
      byte_valid = (sent < k);
      byte_in    = data_q[(sent < 64) ? sent : 63];
      obs_v[c]   = {serOut, busy, done, error};
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    n_xfer     = sent;
  endtask

  // Expected waveform from the frame definition
  task automatic build_model(input logic [1:0] p, input logic [5:0] l, input int k,
                             input bit hold, input int ncyc);
    int L;
    int c;
    logic [7:0] h;
    logic [7:0] d;
    logic good;
    L = eff_len(l);
    h = {l, p};
    c = 1;
    exp_v[c] = 4'b0100; c++;
    for (int i = 7; i >= 0; i--) begin
      exp_v[c] = {h[i], 3'b100}; c++;
    end
    for (int b = 0; b < L; b++) begin
      d = (b < k) ? data_q[b] : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        exp_v[c] = {d[j], 3'b100}; c++;
      end
    end
    good = (k >= L);
    exp_v[c] = {good, 1'b1, good, !good}; c++;
    for (int g = 0; g < int'(GAP_CYC); g++) begin
      exp_v[c] = 4'b1100; c++;
    end
    while (c <= ncyc) begin
      exp_v[c] = hold ? 4'b0100 : 4'b1000; c++;
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 64; i++) data_q[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; port = 2'd3; len = 6'd5; byte_in = 8'hFF; byte_valid = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (serOut !== 1'b1) begin n_fail++; $display("FAIL reset_serOut: got %b expected 1", serOut); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    start = 1'b0; byte_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_directed_a5();
    int n;
    data_q[0] = 8'hA5;
    n = frame_cycles(6'd1);
    run_frame(2'd2, 6'd1, 1, 1'b0, n);
    build_model(2'd2, 6'd1, 1, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL a5_frame cycle %0d: got {ser,busy,done,err}=%b expected %b", c, obs_v[c], exp_v[c]); end
    end
    n_checks++; if (obs_v[18][1] !== 1'b1) begin n_fail++; $display("FAIL a5_done_c18: got %b expected 1", obs_v[18][1]); end
    n_checks++; if (obs_v[19 + GAP_CYC][2] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_low: got %b expected 0", obs_v[19 + GAP_CYC][2]); end
    n_checks++; if (n_xfer !== 1) begin n_fail++; $display("FAIL a5_xfer_count: got %0d expected 1", n_xfer); end
  endtask

  task automatic test_full_stream();
    int n;
    randomize_data();
    n = frame_cycles(6'd0);
    run_frame(2'($urandom), 6'd0, 64, 1'b0, n);
    build_model(port, 6'd0, 64, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL len64_frame cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]); end
    end
    n_checks++; if (obs_v[522] !== 4'b1110) begin n_fail++; $display("FAIL len64_stop_c522: got %b expected 1110", obs_v[522]); end
    n_checks++; if (n_xfer !== 64) begin n_fail++; $display("FAIL len64_xfer_count: got %0d expected 64", n_xfer); end
  endtask

  task automatic test_underrun();
    int n;
    int l;
    int k;
    for (int it = 0; it < 4; it++) begin
      randomize_data();
      l = (it == 0) ? 2 : int'($urandom_range(1, 63));
      k = (it == 0) ? 1 : int'($urandom_range(0, l - 1));
      n = frame_cycles(6'(l));
      run_frame(2'($urandom), 6'(l), k, 1'b0, n);
      build_model(port, 6'(l), k, 1'b0, n);
      for (int c = 1; c <= n; c++) begin
        n_checks++;
        if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL underrun_frame len=%0d k=%0d cycle %0d: got %b expected %b", l, k, c, obs_v[c], exp_v[c]); end
      end
      n_checks++; if (n_xfer !== k) begin n_fail++; $display("FAIL underrun_xfer_count: got %0d expected %0d", n_xfer, k); end
    end
  endtask

  task automatic test_random_frames();
    int n;
    logic [5:0] l;
    for (int it = 0; it < 5; it++) begin
      randomize_data();
      l = 6'($urandom);
      n = frame_cycles(l);
      run_frame(2'($urandom), l, eff_len(l), 1'b0, n);
      build_model(port, l, eff_len(l), 1'b0, n);
      for (int c = 1; c <= n; c++) begin
        n_checks++;
        if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL random_frame len=%0d cycle %0d: got %b expected %b", l, c, obs_v[c], exp_v[c]); end
      end
      n_checks++; if (n_xfer !== eff_len(l)) begin n_fail++; $display("FAIL random_xfer_count: got %0d expected %0d", n_xfer, eff_len(l)); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int w;
    logic [5:0] l;
    randomize_data();
    l = 6'($urandom_range(1, 8));
    n = frame_cycles(l);
    run_frame(2'($urandom), l, eff_len(l), 1'b1, n);
    build_model(port, l, eff_len(l), 1'b1, n);
    for (int c = 1; c <= n; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL b2b_frame cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]); end
    end
    w = 0;
    while (busy !== 1'b0 && w < MAXC) begin
      tick();
      w++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_second_frame_end: busy got %b expected 0 within %0d cycles", busy, MAXC); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [5:0] l;
    randomize_data();
    run_frame(2'd1, 6'd4, 4, 1'b0, 20);
    rst = 1'b0;
    tick();
    n_checks++; if (serOut !== 1'b1) begin n_fail++; $display("FAIL midrst_serOut: got %b expected 1", serOut); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_byte_ready: got %b expected 0", byte_ready); end
    n_checks++; if ({done, error} !== 2'b00) begin n_fail++; $display("FAIL midrst_done_error: got %b expected 00", {done, error}); end
    rst = 1'b1;
    randomize_data();
    l = 6'($urandom_range(1, 16));
    n = frame_cycles(l);
    run_frame(2'($urandom), l, eff_len(l), 1'b0, n);
    build_model(port, l, eff_len(l), 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL midrst_new_frame cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]); end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; port = '0; len = '0; byte_in = '0; byte_valid = 1'b0;
    for (int i = 0; i < 64; i++) data_q[i] = 8'h00;
    test_reset();
    test_directed_a5();
    test_full_stream();
    test_underrun();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
